// File: rtl/pong_ball_engine.sv
// pong_ball_engine: ball motion, paddle bounce, scoring and serve/pause/game-over sequencing for one pong table.
module pong_ball_engine #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int BALL_SZ  = 8,
  parameter int PAD_W    = 8,
  parameter int PAD_H    = 64,
  parameter int PAD_XL   = 16,
  parameter int PAD_XR   = 616,
  parameter int SPEED    = 2,
  parameter int PAUSE_FR = 60,
  parameter int WIN      = 9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       serve,
  input  logic [9:0] pad_l_y,
  input  logic [9:0] pad_r_y,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic       hit,
  output logic       point,
  output logic       game_over
);
  localparam logic [10:0] SZ = 11'(BALL_SZ);
  localparam logic [10:0] SP = 11'(SPEED);
  localparam logic [10:0] PH = 11'(PAD_H);
  localparam logic [10:0] XL = 11'(PAD_XL + PAD_W);
  localparam logic [10:0] XR = 11'(PAD_XR - BALL_SZ);
  localparam logic [10:0] XM = 11'(H_ACTIVE - BALL_SZ - SPEED);
  localparam logic [10:0] YM = 11'(V_ACTIVE - BALL_SZ);
  localparam logic [10:0] CX = 11'((H_ACTIVE - BALL_SZ) / 2);
  localparam logic [10:0] CY = 11'((V_ACTIVE - BALL_SZ) / 2);
  localparam logic [3:0]  W  = 4'(WIN);
  localparam logic [5:0]  PF = 6'(PAUSE_FR - 1);
  typedef enum logic [1:0] {IDLE, PLAY, PAUSE, OVER} state_t;
  state_t state, state_nxt;
  logic [10:0] bx, by, pl, pr, x_mv, y_mv, x_nxt, y_nxt;
  logic dir_x, dir_y, dx_mv, dy_mv, dx_nxt, dy_nxt;
  logic ov_l, ov_r, hit_l, hit_r, miss_l, miss_r, win, hit_nxt, point_nxt;
  logic [3:0] sl_nxt, sr_nxt;
  logic [5:0] cnt, cnt_nxt;
  assign bx = {1'b0, ball_x};
  assign by = {1'b0, ball_y};
  assign pl = {1'b0, pad_l_y};
  assign pr = {1'b0, pad_r_y};
  assign ov_l = (by + SZ > pl) && (by < pl + PH);
  assign ov_r = (by + SZ > pr) && (by < pr + PH);
  // dir_x: 1 = right, dir_y: 1 = down
  assign hit_l  = !dir_x && bx >= XL && bx - SP <= XL && ov_l;
  assign hit_r  = dir_x && bx <= XR && bx + SP >= XR && ov_r;
  assign miss_l = !dir_x && bx <= SP && !hit_l;
  assign miss_r = dir_x && bx >= XM && !hit_r;
  assign win    = score_l == W || score_r == W;
  assign y_mv  = dir_y ? (by >= YM - SP ? YM : by + SP) : (by <= SP ? 11'd0 : by - SP);
  assign dy_mv = dir_y ? (by < YM - SP) : (by <= SP);
  assign x_mv  = hit_l ? XL : hit_r ? XR : dir_x ? bx + SP : bx - SP;
  assign dx_mv = hit_l ? 1'b1 : hit_r ? 1'b0 : dir_x;
  always_comb begin
    state_nxt = state;
    x_nxt     = bx;
    y_nxt     = by;
    dx_nxt    = dir_x;
    dy_nxt    = dir_y;
    sl_nxt    = score_l;
    sr_nxt    = score_r;
    cnt_nxt   = cnt;
    hit_nxt   = 1'b0;
    point_nxt = 1'b0;
    case (state)
      IDLE: begin
        x_nxt     = CX;
        y_nxt     = CY;
        state_nxt = serve ? PLAY : IDLE;
      end
      PLAY: if (frame_tick) begin
        x_nxt   = x_mv;
        y_nxt   = y_mv;
        dx_nxt  = dx_mv;
        dy_nxt  = dy_mv;
        hit_nxt = hit_l | hit_r;
        // the ball keeps heading toward whoever conceded, so the next serve goes their way
        if (miss_l | miss_r) begin
          x_nxt     = CX;
          y_nxt     = CY;
          dx_nxt    = miss_r;
          point_nxt = 1'b1;
          cnt_nxt   = '0;
          state_nxt = PAUSE;
          sl_nxt    = miss_r && score_l != W ? score_l + 4'd1 : score_l;
          sr_nxt    = miss_l && score_r != W ? score_r + 4'd1 : score_r;
        end
      end
      PAUSE: if (frame_tick) begin
        cnt_nxt   = cnt == PF ? 6'd0 : cnt + 6'd1;
        state_nxt = cnt != PF ? PAUSE : win ? OVER : PLAY;
      end
      OVER: begin
        x_nxt = CX;
        y_nxt = CY;
        if (serve) begin
          state_nxt = PLAY;
          sl_nxt    = '0;
          sr_nxt    = '0;
          dx_nxt    = 1'b1;
          dy_nxt    = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ball_x    <= CX[9:0];
      ball_y    <= CY[9:0];
      dir_x     <= 1'b1;
      dir_y     <= 1'b1;
      score_l   <= '0;
      score_r   <= '0;
      cnt       <= '0;
      hit       <= 1'b0;
      point     <= 1'b0;
      game_over <= 1'b0;
    end else begin
      state     <= state_nxt;
      ball_x    <= x_nxt[9:0];
      ball_y    <= y_nxt[9:0];
      dir_x     <= dx_nxt;
      dir_y     <= dy_nxt;
      score_l   <= sl_nxt;
      score_r   <= sr_nxt;
      cnt       <= cnt_nxt;
      hit       <= hit_nxt;
      point     <= point_nxt;
      game_over <= state_nxt == OVER;
    end
  end
endmodule
